// File: rtl/bcxtreme_pkg.sv
// Shared types for the bcxtreme front end: SHA-256 midstate layout and scheduler states.
package bcxtreme_pkg;

  localparam int PIPE_LATENCY_DEFAULT = 131;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } HashState;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/bcxtreme_work_scheduler_nonce_delay_line.sv
// Fixed-depth shift of {tag, nonce}; a synchronous clear kills every in-flight tag so
// stale victories from a finished or aborted job cannot be matched.
module nonce_delay_line #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 131
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             tag_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             tag_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] tag_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        tag_q[i] <= clear_i ? 1'b0 : tag_q[i-1];
      end
      tag_q[0] <= tag_i & ~clear_i;
    end
  end

  // NOTE: the payload has no reset on purpose; it is only ever consumed when its tag
  // is set, and the tags are reset, so resetting a wide shift array buys nothing.
  always_ff @(posedge clk) begin
    for (int i = DEPTH - 1; i > 0; i--) begin
      data_q[i] <= data_q[i-1];
    end
    data_q[0] <= data_i;
  end

  assign tag_o  = tag_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/bcxtreme_work_scheduler.sv
// Job front end: latches one job, sweeps the nonce field one value per cycle, and maps a
// delayed victory back to its nonce to report found/exhausted exactly once per job.
module bcxtreme_work_scheduler
  import bcxtreme_pkg::*;
#(
  parameter int PARTITIONBITS = 1,
  parameter int NONCE_BITS    = 32 - PARTITIONBITS,
  parameter int PIPE_LATENCY  = PIPE_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  HashState              job_hash_i,
  input  logic [2:0][31:0]      job_words_i,
  input  logic                  abort_i,
  output logic                  valid_o,
  output logic                  newblock_o,
  output HashState              hashstate_o,
  output logic [2:0][31:0]      words_o,
  output logic [NONCE_BITS-1:0] nonce_o,
  input  logic                  victory_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  result_found_o,
  output logic [NONCE_BITS-1:0] result_nonce_o
);

  localparam int                  DRAIN_W    = $clog2(PIPE_LATENCY + 1);
  localparam logic [NONCE_BITS-1:0] NONCE_LAST = '1;

  sched_state_t            state_q, state_d;
  logic [NONCE_BITS-1:0]   nonce_q, nonce_d;
  logic                    newblock_q, newblock_d;
  HashState                hash_q, hash_d;
  logic [2:0][31:0]        words_q, words_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic                    found_q, found_d;
  logic [NONCE_BITS-1:0]   rnonce_q, rnonce_d;

  logic                    dl_tag;
  logic [NONCE_BITS-1:0]   dl_nonce;
  logic                    win;
  logic                    tag_clear;

  // A victory only counts while a job is live and the delayed slot carried a real issue.
  assign win = victory_i & dl_tag & ((state_q == ISSUE) | (state_q == DRAIN));

  // NOTE: every _d gets its hold value first so no path through the case leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    nonce_d    = nonce_q;
    newblock_d = newblock_q;
    hash_d     = hash_q;
    words_d    = words_q;
    drain_d    = drain_q;
    found_d    = found_q;
    rnonce_d   = rnonce_q;

    case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          state_d    = ISSUE;
          hash_d     = job_hash_i;
          words_d    = job_words_i;
          newblock_d = 1'b1;
        end
      end
      ISSUE: begin
        nonce_d    = nonce_q + NONCE_BITS'(1);
        newblock_d = 1'b0;
        if (abort_i) begin
          state_d = IDLE;
        end else if (win) begin
          state_d  = REPORT;
          found_d  = 1'b1;
          rnonce_d = dl_nonce;
        end else if (nonce_q == NONCE_LAST) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(PIPE_LATENCY);
        end
      end
      DRAIN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (win) begin
          state_d  = REPORT;
          found_d  = 1'b1;
          rnonce_d = dl_nonce;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
          // The last drain cycle is the one that sees the victory slot of the final nonce.
          if (drain_q == DRAIN_W'(1)) begin
            state_d  = REPORT;
            found_d  = 1'b0;
            rnonce_d = '0;
          end
        end
      end
      REPORT: begin
        if (abort_i || result_ready_i) begin
          state_d  = IDLE;
          found_d  = 1'b0;
          rnonce_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != ISSUE) begin
      nonce_d    = '0;
      newblock_d = 1'b0;
    end
  end

  assign tag_clear = (state_d == IDLE) || (state_d == REPORT);

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      nonce_q    <= '0;
      newblock_q <= 1'b0;
      hash_q     <= '0;
      words_q    <= '0;
      drain_q    <= '0;
      found_q    <= 1'b0;
      rnonce_q   <= '0;
    end else begin
      state_q    <= state_d;
      nonce_q    <= nonce_d;
      newblock_q <= newblock_d;
      hash_q     <= hash_d;
      words_q    <= words_d;
      drain_q    <= drain_d;
      found_q    <= found_d;
      rnonce_q   <= rnonce_d;
    end
  end

  nonce_delay_line #(
    .WIDTH (NONCE_BITS),
    .DEPTH (PIPE_LATENCY)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tag_clear),
    .tag_i   (valid_o),
    .data_i  (nonce_q),
    .tag_o   (dl_tag),
    .data_o  (dl_nonce)
  );

  assign job_ready_o    = (state_q == IDLE);
  assign valid_o        = (state_q == ISSUE);
  assign newblock_o     = newblock_q;
  assign nonce_o        = nonce_q;
  assign hashstate_o    = hash_q;
  assign words_o        = words_q;
  assign result_valid_o = (state_q == REPORT);
  assign result_found_o = found_q;
  assign result_nonce_o = rnonce_q;

endmodule

// File: tb/tb_bcxtreme_work_scheduler.sv
// Bench for bcxtreme_work_scheduler with a 4-bit nonce field and a 5-cycle pipeline.
module tb_bcxtreme_work_scheduler;
  import bcxtreme_pkg::*;

  localparam int NB = 4;
  localparam int L  = 5;
  localparam int NN = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid_i;
  logic             job_ready_o;
  HashState         job_hash_i;
  logic [2:0][31:0] job_words_i;
  logic             abort_i;
  logic             valid_o;
  logic             newblock_o;
  HashState         hashstate_o;
  logic [2:0][31:0] words_o;
  logic [NB-1:0]    nonce_o;
  logic             victory_i;
  logic             result_valid_o;
  logic             result_ready_i;
  logic             result_found_o;
  logic [NB-1:0]    result_nonce_o;

  int checks = 0;
  int errors = 0;

  bcxtreme_work_scheduler #(
    .NONCE_BITS   (NB),
    .PIPE_LATENCY (L)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .job_valid_i    (job_valid_i),
    .job_ready_o    (job_ready_o),
    .job_hash_i     (job_hash_i),
    .job_words_i    (job_words_i),
    .abort_i        (abort_i),
    .valid_o        (valid_o),
    .newblock_o     (newblock_o),
    .hashstate_o    (hashstate_o),
    .words_o        (words_o),
    .nonce_o        (nonce_o),
    .victory_i      (victory_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_found_o (result_found_o),
    .result_nonce_o (result_nonce_o)
  );

  always #5 clk = ~clk;

  // Cycle k of a job is the interval after the k-th edge; the handshake happens in cycle 0.
  typedef struct {
    int         v0;
    int         v1;
    int         ab;
    int         rd;
    bit         found;
    logic [3:0] nonce;
    int         e_end;
    bit         aborted;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: nonce n is issued in cycle n+1 and its victory arrives in cycle n+1+L.
  // The lowest matching nonce wins; the sweep otherwise ends after the last nonce's slot.
  function automatic void model(input int v0, input int v1, input int ab_in,
                                output int ab, output bit found, output logic [3:0] n,
                                output int e_end, output bit aborted);
    int vs [2];
    int best;
    int nat_end;
    vs[0] = v0;
    vs[1] = v1;
    best  = NN;
    foreach (vs[i]) begin
      if (vs[i] - L - 1 >= 0 && vs[i] - L - 1 < best) best = vs[i] - L - 1;
    end
    nat_end = (best < NN) ? best + 1 + L : NN + L;
    aborted = (ab_in >= 1 && ab_in <= nat_end);
    ab      = aborted ? ab_in : -1;
    e_end   = aborted ? ab_in : nat_end;
    found   = !aborted && best < NN;
    n       = found ? 4'(best) : 4'd0;
  endfunction

  task automatic run_job(input int v0, input int v1, input int ab, input int rd,
                         input bit e_found, input logic [3:0] e_nonce,
                         input int e_end, input bit e_abort);
    HashState         h;
    logic [2:0][31:0] w;
    int r_cycle;
    int rdy_k;
    int last_k;
    bit exp_valid;
    bit exp_rv;
    bit exp_jr;
    h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    w = {$urandom, $urandom, $urandom};
    victory_i      = 1'b0;
    abort_i        = 1'b0;
    result_ready_i = 1'b0;
    check("job_ready at start", 32'(job_ready_o), 32'd1);
    job_valid_i = 1'b1;
    job_hash_i  = h;
    job_words_i = w;
    r_cycle = e_end + 1;
    rdy_k   = r_cycle + rd;
    last_k  = e_abort ? e_end + 1 : rdy_k + 1;
    for (int k = 1; k <= last_k; k++) begin
      step();
      job_valid_i    = !e_abort && k >= r_cycle && k <= rdy_k;
      job_hash_i     = ~h;
      job_words_i    = ~w;
      victory_i      = (k == v0) || (k == v1);
      abort_i        = (k == ab);
      result_ready_i = !e_abort && k == rdy_k;
      exp_valid = k <= NN && k <= e_end;
      exp_rv    = !e_abort && k >= r_cycle && k <= rdy_k;
      exp_jr    = e_abort ? (k > e_end) : (k > rdy_k);
      check($sformatf("valid_o k=%0d", k), 32'(valid_o), 32'(exp_valid));
      if (exp_valid) begin
        check($sformatf("nonce_o k=%0d", k), 32'(nonce_o), 32'(k - 1));
        check($sformatf("newblock_o k=%0d", k), 32'(newblock_o), 32'(k == 1));
        check($sformatf("hashstate_o k=%0d", k), 32'(hashstate_o == h), 32'd1);
        check($sformatf("words_o k=%0d", k), 32'(words_o == w), 32'd1);
      end
      check($sformatf("result_valid_o k=%0d", k), 32'(result_valid_o), 32'(exp_rv));
      if (exp_rv) begin
        check($sformatf("result_found_o k=%0d", k), 32'(result_found_o), 32'(e_found));
        check($sformatf("result_nonce_o k=%0d", k), 32'(result_nonce_o), 32'(e_nonce));
      end
      check($sformatf("job_ready_o k=%0d", k), 32'(job_ready_o), 32'(exp_jr));
    end
    job_valid_i    = 1'b0;
    victory_i      = 1'b0;
    abort_i        = 1'b0;
    result_ready_i = 1'b0;
  endtask

  initial begin
    int ab;
    bit found;
    logic [3:0] n;
    int e_end;
    bit aborted;

    //           v0  v1  ab  rd  fnd nonce end abort
    tbl[0] = '{-1, -1, -1,  0, 1'b0, 4'd0,  21, 1'b0};  // exhausted sweep
    tbl[1] = '{12, -1, -1,  0, 1'b1, 4'd6,  12, 1'b0};  // win on nonce 6
    tbl[2] = '{21, -1, -1,  1, 1'b1, 4'd15, 21, 1'b0};  // win on last nonce, in drain
    tbl[3] = '{16, -1, -1,  0, 1'b1, 4'd10, 16, 1'b0};  // win coincides with last issue
    tbl[4] = '{ 6, -1,  4,  0, 1'b0, 4'd0,   4, 1'b1};  // abort at nonce 3, later victory
    tbl[5] = '{ 9, -1, -1, 10, 1'b1, 4'd3,   9, 1'b0};  // consumer stalls 10 cycles
    tbl[6] = '{ 3,  8, -1,  2, 1'b1, 4'd2,   8, 1'b0};  // untagged victory ignored
    tbl[7] = '{14, 10, -1,  0, 1'b1, 4'd4,  10, 1'b0};  // first victory wins
    tbl[8] = '{-1, -1, 19,  0, 1'b0, 4'd0,  19, 1'b1};  // abort during drain
    tbl[9] = '{22, -1, -1,  0, 1'b0, 4'd0,  21, 1'b0};  // victory after report ignored

    rst            = 1'b1;
    job_valid_i    = 1'b0;
    job_hash_i     = '0;
    job_words_i    = '0;
    abort_i        = 1'b0;
    victory_i      = 1'b0;
    result_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset job_ready_o", 32'(job_ready_o), 32'd1);
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset newblock_o", 32'(newblock_o), 32'd0);
    check("reset result_valid_o", 32'(result_valid_o), 32'd0);
    check("reset result_found_o", 32'(result_found_o), 32'd0);
    check("reset nonce_o", 32'(nonce_o), 32'd0);
    check("reset result_nonce_o", 32'(result_nonce_o), 32'd0);
    check("reset hashstate_o", 32'(hashstate_o == '0), 32'd1);
    check("reset words_o", 32'(words_o == '0), 32'd0 + 32'd1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_job(tbl[i].v0, tbl[i].v1, tbl[i].ab, tbl[i].rd,
              tbl[i].found, tbl[i].nonce, tbl[i].e_end, tbl[i].aborted);
    end

    // Abort while a result is pending drops it without a handshake.
    job_valid_i = 1'b1;
    job_hash_i  = {8{32'h1234_5678}};
    for (int k = 1; k <= 11; k++) begin
      step();
      job_valid_i = 1'b0;
      victory_i   = (k == 8);
      abort_i     = (k == 10);
      if (k == 9 || k == 10) begin
        check($sformatf("abort-report result_valid_o k=%0d", k), 32'(result_valid_o), 32'd1);
        check($sformatf("abort-report result_nonce_o k=%0d", k), 32'(result_nonce_o), 32'd2);
      end
      if (k == 11) begin
        check("abort-report result_valid_o after", 32'(result_valid_o), 32'd0);
        check("abort-report job_ready_o after", 32'(job_ready_o), 32'd1);
      end
    end
    abort_i   = 1'b0;
    victory_i = 1'b0;

    // Asynchronous reset in the middle of a sweep, applied between clock edges.
    job_valid_i = 1'b1;
    job_hash_i  = {8{32'hdead_beef}};
    job_words_i = {3{32'hcafe_f00d}};
    step();
    job_valid_i = 1'b0;
    step();
    step();
    check("pre-reset valid_o", 32'(valid_o), 32'd1);
    check("pre-reset nonce_o", 32'(nonce_o), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check("async reset valid_o", 32'(valid_o), 32'd0);
    check("async reset nonce_o", 32'(nonce_o), 32'd0);
    check("async reset newblock_o", 32'(newblock_o), 32'd0);
    check("async reset job_ready_o", 32'(job_ready_o), 32'd1);
    check("async reset result_valid_o", 32'(result_valid_o), 32'd0);
    check("async reset hashstate_o", 32'(hashstate_o == '0), 32'd1);
    check("async reset words_o", 32'(words_o == '0), 32'd1);
    #2;
    rst = 1'b0;
    step();
    run_job(-1, -1, -1, 0, 1'b0, 4'd0, 21, 1'b0);

    // Random jobs against the reference model.
    for (int j = 0; j < 40; j++) begin
      int v0;
      int v1;
      int ab_in;
      int rd;
      v0    = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 24));
      v1    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 24)) : -1;
      ab_in = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 22)) : -1;
      rd    = int'($urandom_range(0, 3));
      model(v0, v1, ab_in, ab, found, n, e_end, aborted);
      run_job(v0, v1, ab, rd, found, n, e_end, aborted);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
